// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Fetch/decode/control sequencer for the 8-bit datapath. Fetches 32-bit
//   instructions over a req/ack handshake, latches them in an instruction
//   register and walks FETCH -> DECODE -> EXECUTE -> WRITEBACK, driving the
//   8x8 register file controls, ALU select and immediate path. Owns the PC.
//
//   Optional feature macro: SEQ_BRANCH_EN (opcode 0x07 = BEQ when defined,
//   otherwise 0x07 is an undefined opcode).
//
// Ports
//   i_clk          system clock, rising edge
//   i_reset        synchronous active-high reset
//   i_imem_ack     instruction memory has valid i_instr this cycle
//   i_instr        instruction word
//   i_alu_zero     ALU result is zero (BEQ only)
//   o_pc           fetch address (word addressed)
//   o_imem_req     fetch request
//   o_rf_inaddr    register file write address   IR[18:16]
//   o_rf_out1addr  register file read port 1      IR[10:8]
//   o_rf_out2addr  register file read port 2      IR[2:0]
//   o_rf_ctrl      1 = read / no write, 0 = write
//   o_alu_sel      000 fwd, 001 add, 010 and, 011 or
//   o_neg_sel      negate operand 2 before the ALU
//   o_imm_sel      operand 2 = immediate
//   o_imm          IR[7:0]
//   o_halt         sequencer halted
//   o_illegal      sticky undefined-opcode flag

module instr_sequencer #(
    parameter int PC_WIDTH = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_imem_ack,
    input  logic [31:0]         i_instr,
    input  logic                i_alu_zero,
    output logic [PC_WIDTH-1:0] o_pc,
    output logic                o_imem_req,
    output logic [2:0]          o_rf_inaddr,
    output logic [2:0]          o_rf_out1addr,
    output logic [2:0]          o_rf_out2addr,
    output logic                o_rf_ctrl,
    output logic [2:0]          o_alu_sel,
    output logic                o_neg_sel,
    output logic                o_imm_sel,
    output logic [7:0]          o_imm,
    output logic                o_halt,
    output logic                o_illegal
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALTED    = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   w_pc_nxt;
    logic [31:0]           r_ir;
    // IR=0 after reset would decode as LOADI; this flag keeps the decoded
    // outputs quiet until a real instruction has been fetched.
    logic                  r_ir_vld;
    logic                  r_illegal;
    logic                  w_ir_load;
    logic                  w_set_illegal;

    logic [7:0]            w_op;
    logic                  w_is_wr;
    logic [2:0]            w_alu;
    logic                  w_neg;
    logic                  w_imm_sel;
    logic                  w_jump;
    logic                  w_beq;
    logic                  w_halt_op;
    logic                  w_undef;
    logic                  w_taken;
    logic [PC_WIDTH-1:0]   w_off;
    logic                  w_unused;

    assign w_op = r_ir[31:24];

    // Instruction decode, purely from the instruction register
    always_comb begin
        w_is_wr   = 1'b0;
        w_alu     = 3'b000;
        w_neg     = 1'b0;
        w_imm_sel = 1'b0;
        w_jump    = 1'b0;
        w_beq     = 1'b0;
        w_halt_op = 1'b0;
        w_undef   = 1'b0;
        if (r_ir_vld) begin
            case (w_op)
                8'h00: begin w_is_wr = 1'b1; w_imm_sel = 1'b1; end
                8'h01: w_is_wr = 1'b1;
                8'h02: begin w_is_wr = 1'b1; w_alu = 3'b001; end
                8'h03: begin w_is_wr = 1'b1; w_alu = 3'b001; w_neg = 1'b1; end
                8'h04: begin w_is_wr = 1'b1; w_alu = 3'b010; end
                8'h05: begin w_is_wr = 1'b1; w_alu = 3'b011; end
                8'h06: w_jump = 1'b1;
`ifdef SEQ_BRANCH_EN
                // compare src1/src2 by subtracting; branch decided in WRITEBACK
                8'h07: begin w_beq = 1'b1; w_alu = 3'b001; w_neg = 1'b1; end
`else
                8'h07: w_undef = 1'b1;
`endif
                8'hFF: w_halt_op = 1'b1;
                default: w_undef = 1'b1;
            endcase
        end
    end

    // Relative target: PC + 1 + sign-extended IR[23:16], wrapping
    assign w_off   = PC_WIDTH'($signed(r_ir[23:16]));
    assign w_taken = w_jump | (w_beq & i_alu_zero);

    // Next-state and control outputs
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_ir_load     = 1'b0;
        w_set_illegal = 1'b0;
        o_imem_req    = 1'b0;
        o_rf_ctrl     = 1'b1;
        o_halt        = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_imem_req = 1'b1;
                if (i_imem_ack) begin
                    w_ir_load   = 1'b1;
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                w_set_illegal = w_undef;
                w_state_nxt   = S_EXECUTE;
            end
            S_EXECUTE: w_state_nxt = S_WRITEBACK;
            S_WRITEBACK: begin
                o_rf_ctrl = ~w_is_wr;
                if (w_halt_op) begin
                    w_state_nxt = S_HALTED;
                end else begin
                    w_state_nxt = S_FETCH;
                    w_pc_nxt    = w_taken ? (r_pc + PC_WIDTH'(1) + w_off)
                                          : (r_pc + PC_WIDTH'(1));
                end
            end
            S_HALTED: o_halt = 1'b1;
            default:  w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_FETCH;
            r_pc      <= '0;
            r_ir      <= '0;
            r_ir_vld  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_ir_load) begin
                r_ir     <= i_instr;
                r_ir_vld <= 1'b1;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign o_pc          = r_pc;
    assign o_rf_inaddr   = r_ir[18:16];
    assign o_rf_out1addr = r_ir[10:8];
    assign o_rf_out2addr = r_ir[2:0];
    assign o_imm         = r_ir[7:0];
    assign o_alu_sel     = w_alu;
    assign o_neg_sel     = w_neg;
    assign o_imm_sel     = w_imm_sel;
    assign o_illegal     = r_illegal;

    // IR[15:11] carries no field; ALU_ZERO is unused without branches
    assign w_unused = ^{i_alu_zero, r_ir[15:11]};

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Fetch/decode/control sequencer for the 8-bit datapath: fetches 32-bit instructions through a request/acknowledge handshake, holds them in an instruction register and walks a four-state FSM that drives the 8x8 register file's address and read/write control, the ALU operation select and the immediate path. Sits directly upstream of the register file and ALU; owns the program counter.

## Interface
- PC_WIDTH, 8, program-counter width; word-addressed, one instruction per address

- CLK  in  1  system clock; all state changes on rising edge
- RESET  in  1  synchronous, active-high reset
- IMEM_ACK  in  1  instruction memory has valid INSTR this cycle
- INSTR  in  32  instruction word
- ALU_ZERO  in  1  ALU result is zero (used only by BEQ)
- PC  out  PC_WIDTH  fetch address
- IMEM_REQ  out  1  fetch request
- RF_INADDR  out  3  write address, IR[18:16]
- RF_OUT1ADDR  out  3  read port 1 address, IR[10:8]
- RF_OUT2ADDR  out  3  read port 2 address, IR[2:0]
- RF_CTRL  out  1  register-file control: 1 = read/no write, 0 = write
- ALU_SEL  out  3  000 forward, 001 add, 010 and, 011 or
- NEG_SEL  out  1  negate operand 2 (two's complement) before ALU
- IMM_SEL  out  1  operand 2 = IMM instead of read port 2
- IMM  out  8  IR[7:0]
- HALT  out  1  sequencer halted
- ILLEGAL  out  1  sticky: undefined opcode seen

## Operation
- Opcode IR[31:24]: 0x00 LOADI dest<=imm; 0x01 MOV dest<=src2; 0x02 ADD; 0x03 SUB; 0x04 AND; 0x05 OR; 0x06 JUMP; 0x07 BEQ (see Configuration); 0xFF HALT; anything else: NOP, sets ILLEGAL.
- Decode fields: LOADI IMM_SEL=1, ALU_SEL=000; MOV ALU_SEL=000; ADD 001; SUB 001+NEG_SEL; AND 010; OR 011; BEQ 001+NEG_SEL; others all zero.
- All outputs are functions of state, IR and PC only; no combinational path from INSTR, IMEM_ACK or ALU_ZERO to any output.
- States: FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH; HALTED terminal.
  - FETCH: IMEM_REQ=1; stay until IMEM_ACK=1, then IR<=INSTR, go DECODE.
  - DECODE: RF_CTRL=1; register file samples operands at the closing edge.
  - EXECUTE: ALU settles; RF_CTRL=1.
  - WRITEBACK: RF_CTRL=0 only for LOADI/MOV/ADD/SUB/AND/OR; else 1. PC update; go FETCH, or HALTED if HALT opcode.
  - HALTED: HALT=1, IMEM_REQ=0, RF_CTRL=1, PC frozen; left only by RESET.
- PC update in WRITEBACK: JUMP, or BEQ with ALU_ZERO=1: PC <= PC + 1 + sign_extend(IR[23:16]); HALT: unchanged; otherwise PC+1. All modulo 2^PC_WIDTH (wraps, no flag).
- IMEM_ACK outside FETCH ignored.
- ILLEGAL set in DECODE of an undefined opcode, cleared only by RESET.

## Timing
- Reset (RESET high at a rising edge): state FETCH, PC=0, IR=0, ILLEGAL=0. Resulting outputs: IMEM_REQ=1, RF_CTRL=1, addresses 0, ALU_SEL=000, NEG_SEL=0, IMM_SEL=0, IMM=0, HALT=0.
- RESET has priority over everything, in any state including HALTED and mid-WRITEBACK; a write in flight that cycle is abandoned (RF_CTRL forced 1 next cycle).
- With IMEM_ACK high on first FETCH cycle: exactly 4 cycles per instruction; each wait cycle adds one.
- RF_CTRL=0 lasts exactly one cycle per writing instruction; never 0 in any other state.
- Decoded outputs valid from DECODE through WRITEBACK; in FETCH they reflect the previous IR.

## Configuration
- SEQ_BRANCH_EN defined: opcode 0x07 is BEQ (compares src1/src2 via subtract, branches on ALU_ZERO in WRITEBACK).
- Undefined: 0x07 is an undefined opcode (NOP, sets ILLEGAL); ALU_ZERO port remains but is ignored.

## Test plan
- Reset then LOADI 0x00_03_00_2A with immediate ack -> RF_CTRL=0 in cycle 4 only, RF_INADDR=3, IMM=0x2A, IMM_SEL=1; PC=1 after.
- SUB 0x03_05_01_02 with ack delayed 3 cycles -> IMEM_REQ high 4 cycles, then RF_OUT1ADDR=1, RF_OUT2ADDR=2, ALU_SEL=001, NEG_SEL=1, write to r5; 7 cycles total.
- PC=0x05, JUMP offset 0xFE -> PC=0x04; PC=0xFF, ADD -> PC wraps to 0x00.
- BEQ offset 0x03 at PC=0x10 with SEQ_BRANCH_EN: ALU_ZERO=1 -> PC=0x14, ALU_ZERO=0 -> 0x11, no RF_CTRL=0; without macro -> ILLEGAL=1, PC=0x11.
- Opcode 0xFF -> HALT=1, IMEM_REQ=0, PC unchanged, further acks ignored; RESET -> PC=0, FETCH.
- RESET asserted in WRITEBACK of ADD -> next cycle RF_CTRL=1, PC=0, ILLEGAL=0, IMEM_REQ=1.
